aes_inv_cipher_iter: RTL and testbench

- Iterative AES-128 inverse cipher; the decryption counterpart to the existing encryption path `Aes_top`.
- Takes a ciphertext and a cipher key over a valid/ready handshake and returns plaintext.
- Expands the key forward to the last round key, then runs one inverse round per clock while regressing the key schedule on the fly.
- Sits beside `Aes_top`; feeding `Aes_top`'s output back through this block must reproduce the original input.

---
 rtl/aes_pkg.sv | 129 ++++++++++++
 rtl/aes_inv_cipher_iter_if.sv | 17 +
 rtl/aes_inv_round.sv | 16 +
 rtl/aes_inv_cipher_iter.sv | 121 ++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// aes_pkg -- AES-128 types, S-box tables and inverse-round helper functions. rev 1.0
package aes_pkg;

    typedef logic [0:127] state_t;
    typedef logic [0:31]  word_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    // Index r holds the round constant consumed when producing round key r.
    localparam logic [7:0] RCON [16] = '{
        8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
        8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t sub_word(input word_t w);
        word_t r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
        return r;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[8*(row + 4*c) +: 8] = s[8*(row + 4*((c - row + 4) % 4)) +: 8];
        return r;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        return r;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c      +: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
            r[32*c + 8  +: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
            r[32*c + 16 +: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
            r[32*c + 24 +: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
        end
        return r;
    endfunction

    function automatic state_t expand_fwd(input state_t rk, input logic [7:0] rc);
        word_t t, n0, n1, n2, n3;
        t  = sub_word(rot_word(rk[96:127])) ^ {rc, 24'h0};
        n0 = rk[0:31]   ^ t;
        n1 = rk[32:63]  ^ n0;
        n2 = rk[64:95]  ^ n1;
        n3 = rk[96:127] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Recovers round key r from round key r+1; rc is the constant that produced r+1.
    function automatic state_t expand_inv(input state_t rk, input logic [7:0] rc);
        word_t w0, w1, w2, w3;
        w3 = rk[96:127] ^ rk[64:95];
        w2 = rk[64:95]  ^ rk[32:63];
        w1 = rk[32:63]  ^ rk[0:31];
        w0 = rk[0:31]   ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_iter_if.sv
`default_nettype none
// aes_inv_cipher_iter_if -- ciphertext/key request and plaintext response handshake. rev 1.0
interface aes_inv_cipher_iter_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in;
    state_t key;
    logic   out_valid;
    logic   out_ready;
    state_t out;

    modport master (output in_valid, in, key, out_ready, input in_ready, out_valid, out);
    modport slave  (input in_valid, in, key, out_ready, output in_ready, out_valid, out);
endinterface
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// aes_inv_round -- one combinational AES inverse round; last drops InvMixColumns. rev 1.0
module aes_inv_round
    import aes_pkg::*;
(
    input  wire state_t st,
    input  wire state_t rk,
    input  wire logic   last,
    output state_t      result
);
    state_t added;

    assign added  = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    assign result = last ? added : inv_mix_columns(added);
endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// aes_inv_cipher_iter -- iterative AES-128 decryption, one inverse round per clock. rev 1.0
// Optional AES_INV_KEY_CACHE_EN: reuse the stored rk10 when the same key is presented again.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input wire logic clk,
    input wire logic reset_n,
    aes_inv_cipher_iter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] KEYEXP = 2'd1;
    localparam logic [1:0] ROUND  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [3:0] LAST_KEY = 4'(NUM_ROUNDS);

    generate
        if (NUM_ROUNDS != 10) begin : g_bad_rounds
            $error("aes_inv_cipher_iter supports only NUM_ROUNDS = 10");
        end
    endgenerate

    logic [1:0] state;
    logic [3:0] cnt;
    state_t     st, rk, out_q, fwd_rk, prev_rk, round_out;
    logic       out_valid_q, in_ready, accept, last;

    assign in_ready      = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign fwd_rk        = expand_fwd(rk, RCON[cnt]);
    assign prev_rk       = expand_inv(rk, RCON[cnt + 4'd1]);
    assign last          = (cnt == 4'd0);

    aes_inv_round u_round (.st(st), .rk(prev_rk), .last(last), .result(round_out));

`ifdef AES_INV_KEY_CACHE_EN
    state_t cache_key, cache_rk10;
    logic   cache_vld, hit;
    assign hit = cache_vld && (bus.key == cache_key);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            st          <= '0;
            rk          <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
            cache_key   <= '0;
            cache_rk10  <= '0;
            cache_vld   <= 1'b0;
`endif
        end else begin
            case (state)
                KEYEXP: begin
                    rk <= fwd_rk;
                    if (cnt == LAST_KEY) begin
                        st    <= st ^ fwd_rk;
                        cnt   <= 4'd9;
                        state <= ROUND;
`ifdef AES_INV_KEY_CACHE_EN
                        cache_rk10 <= fwd_rk;
                        cache_vld  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    st <= round_out;
                    rk <= prev_rk;
                    if (last) begin
                        out_q       <= round_out;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept happens only from IDLE or a draining DONE and overrides the next state.
            if (accept) begin
`ifdef AES_INV_KEY_CACHE_EN
                if (hit) begin
                    st    <= bus.in ^ cache_rk10;
                    rk    <= cache_rk10;
                    cnt   <= 4'd9;
                    state <= ROUND;
                end else begin
                    st        <= bus.in;
                    rk        <= bus.key;
                    cnt       <= 4'd1;
                    state     <= KEYEXP;
                    cache_key <= bus.key;
                    cache_vld <= 1'b0;
                end
`else
                st    <= bus.in;
                rk    <= bus.key;
                cnt   <= 4'd1;
                state <= KEYEXP;
`endif
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// tb_aes_inv_cipher_iter -- randomized round-trip and known-answer bench for aes_inv_cipher_iter. rev 1.0
module tb_aes_inv_cipher_iter;

    typedef bit [7:0] ks_t [176];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    bit [7:0]     sb [256];
    bit           mc_vld = 1'b0;
    logic [0:127] mc_key = '0;

    localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] RK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;

    aes_inv_cipher_iter_if bus_if ();
    aes_inv_cipher_iter #(.NUM_ROUNDS(10)) dut (.clk(clk), .reset_n(reset_n), .bus(bus_if));

    always #5 clk = ~clk;

    function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
        bit [7:0] p = 8'h00;
        bit       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = a << 1;
            if (hi) a ^= 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box built from the multiplicative inverse and affine map.
    task automatic init_tables();
        bit [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic ks_t expand_key(input logic [0:127] k);
        ks_t      w;
        bit [7:0] t [4];
        bit [7:0] tmp;
        bit [7:0] rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[8*i +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[tmp];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ t[j];
        end
        return w;
    endfunction

    function automatic logic [0:127] model_encrypt(input logic [0:127] pt, input logic [0:127] k);
        ks_t          ks;
        bit [7:0]     s [16];
        bit [7:0]     u [16];
        bit [7:0]     a0, a1, a2, a3;
        logic [0:127] r;
        ks = expand_key(k);
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[i];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    u[row + 4*c] = sb[s[row + 4*((c + row) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (rd != 10) begin
                    s[4*c]   = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
                    s[4*c+3] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= ks[16*rd + i];
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    // Expected accept-to-result latency, tracking the optional key cache.
    function automatic int expect_lat(input logic [0:127] k);
`ifdef AES_INV_KEY_CACHE_EN
        if (mc_vld && k == mc_key) return 10;
        mc_vld = 1'b1;
        mc_key = k;
        return 20;
`else
        mc_key = k;
        return 20;
`endif
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_block(input logic [0:127] ct, input logic [0:127] k, input bit hold,
                            output logic [0:127] res, output int lat,
                            output logic [0:127] rk_mid, output bit ready_ok);
        int guard = 0;
        bus_if.out_ready = 1'b1;
        #1;
        while (!bus_if.in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        ready_ok        = bus_if.in_ready;
        bus_if.in_valid = 1'b1;
        bus_if.in       = ct;
        bus_if.key      = k;
        @(posedge clk); #1;
        bus_if.in_valid  = 1'b0;
        bus_if.in        = rand128();
        bus_if.key       = rand128();
        bus_if.out_ready = !hold;
        lat    = 0;
        rk_mid = '0;
        while (!bus_if.out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
            if (lat == 10) rk_mid = dut.rk;
        end
        res = bus_if.out;
    endtask

    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            #1;
            vectors++;
            if (bus_if.in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready);
            end
            vectors++;
            if (bus_if.out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid);
            end
            vectors++;
            if (bus_if.out !== 128'h0) begin
                errors++; $display("FAIL reset_out: got %h want 0", bus_if.out);
            end
            @(posedge clk); #2;
            reset_n = 1'b1;
            @(posedge clk);
        end
    endtask

    task automatic test_fips_b();
        logic [0:127] res, rkm;
        int           lat, el;
        bit           rdy;
        el = expect_lat(KEY_B);
        do_block(CT_B, KEY_B, 1'b0, res, lat, rkm, rdy);
        vectors++;
        if (res !== PT_B) begin errors++; $display("FAIL fips_b_out: got %h want %h", res, PT_B); end
        vectors++;
        if (lat != el) begin errors++; $display("FAIL fips_b_latency: got %0d want %0d", lat, el); end
        if (el == 20) begin
            vectors++;
            if (rkm !== RK_B) begin errors++; $display("FAIL fips_b_rk10: got %h want %h", rkm, RK_B); end
        end
    endtask

    task automatic test_fips_c1();
        logic [0:127] res, rkm;
        int           lat, el;
        bit           rdy;
        el = expect_lat(KEY_C);
        do_block(CT_C, KEY_C, 1'b0, res, lat, rkm, rdy);
        vectors++;
        if (res !== PT_C) begin errors++; $display("FAIL fips_c1_out: got %h want %h", res, PT_C); end
        vectors++;
        if (lat != el) begin errors++; $display("FAIL fips_c1_latency: got %0d want %0d", lat, el); end
    endtask

    task automatic test_backpressure();
        logic [0:127] res, rkm, pt, k, ct;
        int           lat, el;
        bit           rdy;
        pt = rand128(); k = rand128(); ct = model_encrypt(pt, k);
        el = expect_lat(k);
        do_block(ct, k, 1'b1, res, lat, rkm, rdy);
        vectors++;
        if (res !== pt) begin errors++; $display("FAIL bp_first_out: got %h want %h", res, pt); end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus_if.out !== pt) begin
                errors++; $display("FAIL bp_hold_out: cycle %0d got %h want %h", i, bus_if.out, pt);
            end
            vectors++;
            if ({bus_if.out_valid, bus_if.in_ready} !== 2'b10) begin
                errors++; $display("FAIL bp_hold_flags: cycle %0d got valid/ready %b%b want 10",
                                   i, bus_if.out_valid, bus_if.in_ready);
            end
        end
        pt = rand128(); k = rand128(); ct = model_encrypt(pt, k);
        el = expect_lat(k);
        do_block(ct, k, 1'b0, res, lat, rkm, rdy);
        vectors++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL bp_same_cycle_accept: got ready %b want 1", rdy); end
        vectors++;
        if (res !== pt) begin errors++; $display("FAIL bp_second_out: got %h want %h", res, pt); end
        vectors++;
        if (lat != el) begin errors++; $display("FAIL bp_second_latency: got %0d want %0d", lat, el); end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        bus_if.out_ready = 1'b1;
        #1;
        while (!bus_if.in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        bus_if.in_valid = 1'b1; bus_if.in = CT_C; bus_if.key = KEY_C;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        void'(expect_lat(KEY_C));
        repeat (11) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        mc_vld  = 1'b0;
        #1;
        vectors++;
        if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", bus_if.out_valid); end
        vectors++;
        if (bus_if.out !== 128'h0) begin errors++; $display("FAIL midreset_out: got %h want 0", bus_if.out); end
        vectors++;
        if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", bus_if.in_ready); end
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_fips_b();
    endtask

    task automatic test_back_to_back();
        logic [0:127] res, rkm;
        int           lat, el;
        bit           rdy;
        for (int i = 0; i < 3; i++) begin
            el = expect_lat(i < 2 ? KEY_B : KEY_C);
            do_block(i < 2 ? CT_B : CT_C, i < 2 ? KEY_B : KEY_C, 1'b0, res, lat, rkm, rdy);
            vectors++;
            if (res !== (i < 2 ? PT_B : PT_C)) begin
                errors++; $display("FAIL b2b_out: block %0d got %h", i, res);
            end
            vectors++;
            if (lat != el) begin errors++; $display("FAIL b2b_latency: block %0d got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_roundtrip();
        logic [0:127] res, rkm, pt, k, ct;
        int           lat, el;
        bit           rdy;
        k = rand128();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) != 0) k = rand128();
            pt = rand128();
            ct = model_encrypt(pt, k);
            el = expect_lat(k);
            do_block(ct, k, 1'b0, res, lat, rkm, rdy);
            vectors++;
            if (res !== pt) begin errors++; $display("FAIL roundtrip_out: iter %0d got %h want %h", i, res, pt); end
            vectors++;
            if (lat != el) begin errors++; $display("FAIL roundtrip_latency: iter %0d got %0d want %0d", i, lat, el); end
        end
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in        = '0;
        bus_if.key       = '0;
        bus_if.out_ready = 1'b1;
        init_tables();
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_roundtrip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
